k_of_n_detector: RTL and testbench

Parametrised, registered successor to the three-input pair/triple detector: flags when at least K of N input bits are high, then debounces that flag with a hysteresis state machine. The output is asserted only after HOLD consecutive valid hit samples and released only after HOLD consecutive valid miss samples. A saturating counter records detection onsets. Sits between raw sensor or vote inputs and downstream control logic that needs a glitch-free, qualified decision.

---
 rtl/k_of_n_pkg.sv | 21 ++
 rtl/popcount_n.sv | 17 +
 rtl/k_of_n_detector.sv | 152 +++++++++++++++
 tb/tb_k_of_n_detector.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/k_of_n_pkg.sv
// Shared types and width helpers for the k-of-n detector.
package k_of_n_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2,
    DROP   = 2'd3
  } state_t;

  // Width needed to hold a count of 0..n set bits.
  function automatic int unsigned popcnt_w(int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  // Width needed for the run counter to reach hold.
  function automatic int unsigned run_w(int unsigned hold);
    return (hold < 1) ? 1 : $clog2(hold + 1);
  endfunction

endpackage

// File: rtl/popcount_n.sv
// Combinational population count of an N-bit vector.
module popcount_n #(
  parameter int unsigned N = 3,
  parameter int unsigned W = 2
) (
  input  logic [N-1:0] data,
  output logic [W-1:0] count
);

  always_comb begin
    count = '0;
    for (int i = 0; i < N; i++) begin
      count = count + W'(data[i]);
    end
  end

endmodule

// File: rtl/k_of_n_detector.sv
// K-of-N hit detector with a hysteresis debouncer and saturating onset counter.
module k_of_n_detector
  import k_of_n_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned K     = 2,
  parameter int unsigned HOLD  = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_val,
  input  logic [N-1:0]             in_data,
  output logic [popcnt_w(N)-1:0]   popcnt,
  output logic                     detect,
  output logic                     stable,
  output logic                     rise,
  output logic [CNT_W-1:0]         onsets
);

  localparam int unsigned PW = popcnt_w(N);
  localparam int unsigned RW = run_w(HOLD);

  if (N < 1 || K > N || HOLD < 1) begin : g_param_err
    $error("k_of_n_detector: illegal parameters N=%0d K=%0d HOLD=%0d", N, K, HOLD);
  end

  logic [PW-1:0] pop_c;
  logic          hit_c;
  logic          s_val;

  popcount_n #(.N(N), .W(PW)) u_pop (
    .data  (in_data),
    .count (pop_c)
  );

  // K=0 makes every sample a hit; avoids a constant unsigned compare.
  if (K == 0) begin : g_k0
    assign hit_c = 1'b1;
  end else begin : g_kn
    assign hit_c = (pop_c >= PW'(K));
  end

  // Stage 1: sample register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      popcnt <= '0;
      detect <= 1'b0;
      s_val  <= 1'b0;
    end else if (clr) begin
      popcnt <= '0;
      detect <= 1'b0;
      s_val  <= 1'b0;
    end else if (in_val) begin
      popcnt <= pop_c;
      detect <= hit_c;
      s_val  <= 1'b1;
    end else begin
      s_val  <= 1'b0;
    end
  end

  // Stage 2: hysteresis FSM.
  state_t           state, state_d;
  logic [RW-1:0]    run_cnt, run_d;
  logic             stable_d, rise_d;
  logic [CNT_W-1:0] onsets_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      run_cnt <= '0;
      stable  <= 1'b0;
      rise    <= 1'b0;
      onsets  <= '0;
    end else if (clr) begin
      state   <= IDLE;
      run_cnt <= '0;
      stable  <= 1'b0;
      rise    <= 1'b0;
      onsets  <= '0;
    end else begin
      state   <= state_d;
      run_cnt <= run_d;
      stable  <= stable_d;
      rise    <= rise_d;
      onsets  <= onsets_d;
    end
  end

  always_comb begin
    state_d  = state;
    run_d    = run_cnt;
    rise_d   = 1'b0;
    onsets_d = onsets;
    if (s_val) begin
      unique case (state)
        IDLE: begin
          if (detect) begin
            run_d = RW'(1);
            if (HOLD == 1) begin
              state_d = ACTIVE;
              rise_d  = 1'b1;
            end else begin
              state_d = ARM;
            end
          end
        end
        ARM: begin
          if (detect) begin
            if (run_cnt + RW'(1) == RW'(HOLD)) begin
              state_d = ACTIVE;
              run_d   = '0;
              rise_d  = 1'b1;
            end else begin
              run_d = run_cnt + RW'(1);
            end
          end else begin
            run_d   = '0;
            state_d = IDLE;
          end
        end
        ACTIVE: begin
          if (!detect) begin
            run_d   = RW'(1);
            state_d = (HOLD == 1) ? IDLE : DROP;
          end
        end
        DROP: begin
          if (!detect) begin
            if (run_cnt + RW'(1) == RW'(HOLD)) begin
              state_d = IDLE;
              run_d   = '0;
            end else begin
              run_d = run_cnt + RW'(1);
            end
          end else begin
            run_d   = '0;
            state_d = ACTIVE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
    if (rise_d && (onsets != '1)) begin
      onsets_d = onsets + CNT_W'(1);
    end
    stable_d = (state_d == ACTIVE) || (state_d == DROP);
  end

endmodule

// File: tb/tb_k_of_n_detector.sv
// Directed bench for k_of_n_detector across four parameter sets with a window-based reference model.
module tb_k_of_n_detector;

  localparam int PN[4] = '{3, 3, 8, 8};
  localparam int PK[4] = '{2, 2, 0, 8};
  localparam int PH[4] = '{1, 4, 1, 1};
  localparam int PC[4] = '{2, 8, 8, 8};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       val [4];
  logic       clr [4];
  logic [7:0] dat [4];

  logic [1:0] pop0, pop1;
  logic [3:0] pop2, pop3;
  logic [1:0] ons0;
  logic [7:0] ons1, ons2, ons3;
  logic [3:0] det_o, stb_o, rse_o;

  logic [31:0] a_pop [4];
  logic [31:0] a_ons [4];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  k_of_n_detector #(.N(3), .K(2), .HOLD(1), .CNT_W(2)) u_d0 (
    .clk(clk), .rst_n(rst_n), .clr(clr[0]), .in_val(val[0]), .in_data(dat[0][2:0]),
    .popcnt(pop0), .detect(det_o[0]), .stable(stb_o[0]), .rise(rse_o[0]), .onsets(ons0));
  k_of_n_detector #(.N(3), .K(2), .HOLD(4), .CNT_W(8)) u_d1 (
    .clk(clk), .rst_n(rst_n), .clr(clr[1]), .in_val(val[1]), .in_data(dat[1][2:0]),
    .popcnt(pop1), .detect(det_o[1]), .stable(stb_o[1]), .rise(rse_o[1]), .onsets(ons1));
  k_of_n_detector #(.N(8), .K(0), .HOLD(1), .CNT_W(8)) u_d2 (
    .clk(clk), .rst_n(rst_n), .clr(clr[2]), .in_val(val[2]), .in_data(dat[2]),
    .popcnt(pop2), .detect(det_o[2]), .stable(stb_o[2]), .rise(rse_o[2]), .onsets(ons2));
  k_of_n_detector #(.N(8), .K(8), .HOLD(1), .CNT_W(8)) u_d3 (
    .clk(clk), .rst_n(rst_n), .clr(clr[3]), .in_val(val[3]), .in_data(dat[3]),
    .popcnt(pop3), .detect(det_o[3]), .stable(stb_o[3]), .rise(rse_o[3]), .onsets(ons3));

  assign a_pop[0] = 32'(pop0);
  assign a_pop[1] = 32'(pop1);
  assign a_pop[2] = 32'(pop2);
  assign a_pop[3] = 32'(pop3);
  assign a_ons[0] = 32'(ons0);
  assign a_ons[1] = 32'(ons1);
  assign a_ons[2] = 32'(ons2);
  assign a_ons[3] = 32'(ons3);

  task automatic check(string name, int idx, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s dut%0d: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  // Reference model: stable flips once the last HOLD valid samples all disagree with it.
  int m_pop  [4];
  bit m_det  [4];
  bit m_sval [4];
  bit m_stb  [4];
  bit m_rise [4];
  int m_ons  [4];
  bit hist   [4][$];

  task automatic mreset(int i);
    m_pop[i] = 0; m_det[i] = 0; m_sval[i] = 0;
    m_stb[i] = 0; m_rise[i] = 0; m_ons[i] = 0;
    hist[i].delete();
  endtask

  task automatic mstep(int i);
    bit all;
    if (clr[i]) begin
      mreset(i);
      return;
    end
    m_rise[i] = 0;
    if (m_sval[i]) begin
      hist[i].push_back(m_det[i]);
      if (hist[i].size() > PH[i]) void'(hist[i].pop_front());
      if (hist[i].size() == PH[i]) begin
        all = 1;
        for (int j = 0; j < hist[i].size(); j++)
          if (hist[i][j] == m_stb[i]) all = 0;
        if (all) begin
          m_stb[i] = !m_stb[i];
          if (m_stb[i]) begin
            m_rise[i] = 1;
            if (m_ons[i] < (1 << PC[i]) - 1) m_ons[i]++;
          end
        end
      end
    end
    if (val[i]) begin
      m_pop[i]  = $countones(dat[i] & 8'((1 << PN[i]) - 1));
      m_det[i]  = (m_pop[i] >= PK[i]);
      m_sval[i] = 1;
    end else begin
      m_sval[i] = 0;
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 4; i++) begin
      if (!rst_n) mreset(i);
      else        mstep(i);
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      check("popcnt", i, a_pop[i], 32'(m_pop[i]));
      check("detect", i, 32'(det_o[i]), 32'(m_det[i]));
      check("stable", i, 32'(stb_o[i]), 32'(m_stb[i]));
      check("rise", i, 32'(rse_o[i]), 32'(m_rise[i]));
      check("onsets", i, a_ons[i], 32'(m_ons[i]));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(int i, logic v, logic [7:0] d);
    val[i] = v;
    dat[i] = d;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] exp_det = 8'b1110_1000;
  int         exp_pop [8] = '{0, 1, 1, 2, 1, 2, 2, 3};
  int         exp_ons [5] = '{1, 2, 3, 3, 3};
  bit         pv      [5] = '{1, 1, 0, 1, 1};
  bit         seq     [8] = '{0, 0, 0, 1, 0, 0, 0, 0};

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      val[i] = 1'b0; clr[i] = 1'b0; dat[i] = 8'h00;
    end
    #12;
    check("rst_stable", 1, 32'(stb_o[1]), 0);
    check("rst_onsets", 1, a_ons[1], 0);
    check("rst_popcnt", 1, a_pop[1], 0);
    step();
    rst_n = 1'b1;

    // Exhaustive 3-bit inputs, pair/triple equivalence.
    for (int v = 0; v < 8; v++) begin
      drv(0, 1'b1, 8'(v));
      step();
      check("exh_detect", 0, 32'(det_o[0]), 32'(exp_det[v]));
      check("exh_popcnt", 0, a_pop[0], 32'(exp_pop[v]));
    end
    drv(0, 1'b0, 8'h00);
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    step();

    // Onset counter saturation with HOLD=1, CNT_W=2.
    for (int k = 0; k < 5; k++) begin
      drv(0, 1'b1, 8'h06);
      step();
      drv(0, 1'b1, 8'h00);
      step();
      check("sat_onsets", 0, a_ons[0], 32'(exp_ons[k]));
      check("sat_rise", 0, 32'(rse_o[0]), 1);
    end
    drv(0, 1'b0, 8'h00);
    step();

    // HOLD=4 with an in_val gap inside the run.
    for (int k = 0; k < 5; k++) begin
      drv(1, pv[k], 8'h06);
      step();
    end
    drv(1, 1'b0, 8'h00);
    check("hold_pre", 1, 32'(stb_o[1]), 0);
    step();
    check("hold_stable", 1, 32'(stb_o[1]), 1);
    check("hold_rise", 1, 32'(rse_o[1]), 1);
    check("hold_onsets", 1, a_ons[1], 1);
    step();
    check("hold_rise_end", 1, 32'(rse_o[1]), 0);

    // Release: 3 misses, 1 hit, 4 misses.
    for (int k = 0; k < 8; k++) begin
      drv(1, 1'b1, seq[k] ? 8'h06 : 8'h01);
      step();
    end
    check("drop_hold", 1, 32'(stb_o[1]), 1);
    drv(1, 1'b0, 8'h00);
    step();
    step();
    check("drop_stable", 1, 32'(stb_o[1]), 0);
    check("drop_onsets", 1, a_ons[1], 1);

    // Asynchronous reset in ARM with run_cnt=2.
    drv(1, 1'b1, 8'h06);
    step();
    step();
    drv(1, 1'b0, 8'h00);
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_detect", 1, 32'(det_o[1]), 0);
    check("arst_onsets", 1, a_ons[1], 0);
    check("arst_stable", 1, 32'(stb_o[1]), 0);
    #2 rst_n = 1'b1;
    drv(1, 1'b1, 8'h06);
    repeat (3) step();
    drv(1, 1'b0, 8'h00);
    step();
    step();
    check("arst_idle", 1, 32'(stb_o[1]), 0);
    drv(1, 1'b1, 8'h06);
    step();
    drv(1, 1'b0, 8'h00);
    step();
    step();
    check("arst_rearm", 1, 32'(stb_o[1]), 1);
    check("arst_rearm_ons", 1, a_ons[1], 1);

    // Synchronous clear in ARM, with a sample that must be discarded.
    clr[1] = 1'b1;
    step();
    clr[1] = 1'b0;
    drv(1, 1'b1, 8'h06);
    step();
    step();
    drv(1, 1'b0, 8'h00);
    step();
    clr[1] = 1'b1;
    drv(1, 1'b1, 8'h06);
    step();
    clr[1] = 1'b0;
    drv(1, 1'b0, 8'h00);
    check("clr_detect", 1, 32'(det_o[1]), 0);
    check("clr_popcnt", 1, a_pop[1], 0);
    check("clr_onsets", 1, a_ons[1], 0);
    step();
    drv(1, 1'b1, 8'h06);
    repeat (3) step();
    drv(1, 1'b0, 8'h00);
    step();
    step();
    check("clr_idle", 1, 32'(stb_o[1]), 0);
    drv(1, 1'b1, 8'h06);
    step();
    drv(1, 1'b0, 8'h00);
    step();
    step();
    check("clr_rearm", 1, 32'(stb_o[1]), 1);

    // N=8 thresholds at K=0 and K=8.
    drv(2, 1'b1, 8'h00);
    drv(3, 1'b1, 8'h7F);
    step();
    check("k0_detect", 2, 32'(det_o[2]), 1);
    check("k0_popcnt", 2, a_pop[2], 0);
    check("k8_detect_7f", 3, 32'(det_o[3]), 0);
    check("k8_popcnt_7f", 3, a_pop[3], 7);
    drv(2, 1'b1, 8'hA5);
    drv(3, 1'b1, 8'hFF);
    step();
    check("k0_detect_a5", 2, 32'(det_o[2]), 1);
    check("k0_popcnt_a5", 2, a_pop[2], 4);
    check("k8_detect_ff", 3, 32'(det_o[3]), 1);
    check("k8_popcnt_ff", 3, a_pop[3], 8);
    drv(2, 1'b0, 8'h00);
    drv(3, 1'b0, 8'h00);
    step();
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
